// File: rtl/clz_norm_pkg.sv
// Shared constants, result record and arbiter mask helper for the CLZ/normalize block.
package clz_norm_pkg;
    localparam int DATA_W   = 32;
    localparam int LZ_W     = 6;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [LZ_W-1:0]     lz;
        logic [DATA_W-1:0]   mant;
        logic                zero;
    } norm_result_t;

    // Keeps only the requests at or above the round-robin pointer.
    function automatic logic [MAX_REQ-1:0] mask_rotate(input logic [MAX_REQ-1:0] req,
                                                       input logic [MAX_ID_W-1:0] ptr);
        return req & ({MAX_REQ{1'b1}} << ptr);
    endfunction
endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module lzc32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_lz
);
    always_comb begin
        o_lz = 6'd32;
        for (int i = 0; i < 32; i++)
            if (i_data[i]) o_lz = 6'(31 - i);
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; pointer moves past the winner on each transfer.
// CLZ_NORM_ARB_PRIO0_EN gives requester 0 strict priority without moving the pointer.
module rr_arbiter
    import clz_norm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_id
);
    logic [ID_W-1:0]    r_ptr;
    logic [MAX_REQ-1:0] w_rr_req;
    logic [MAX_REQ-1:0] w_masked;
    logic [MAX_REQ-1:0] w_pick_src;
    logic [ID_W-1:0]    w_rr_id;
    logic               w_prio0;

    always_comb begin
        w_rr_req = MAX_REQ'(i_req);
`ifdef CLZ_NORM_ARB_PRIO0_EN
        w_rr_req[0] = 1'b0;
        w_prio0     = i_req[0];
`else
        w_prio0     = 1'b0;
`endif
        // Fall back to the unmasked set to wrap around past the top requester.
        w_masked   = mask_rotate(w_rr_req, MAX_ID_W'(r_ptr));
        w_pick_src = (w_masked != '0) ? w_masked : w_rr_req;
        w_rr_id    = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--)
            if (w_pick_src[i]) w_rr_id = ID_W'(i);
        o_id    = w_prio0 ? '0 : w_rr_id;
        o_grant = (i_en && (i_req != '0)) ? (NREQ'(1) << o_id) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if ((o_grant != '0) && !w_prio0)
            r_ptr <= (o_id == ID_W'(NREQ - 1)) ? '0 : ID_W'(o_id + 1'b1);
    end
endmodule

// File: rtl/clz_norm_arbiter.sv
// Shared leading-zero count / normalize unit behind a round-robin arbiter, two-stage pipeline.
// Define CLZ_NORM_ARB_PRIO0_EN to give requester 0 strict priority.
module clz_norm_arbiter
    import clz_norm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [LZ_W-1:0]        out_lz,
    output logic [DATA_W-1:0]      out_mant,
    output logic                   out_zero
);
    logic              r_s1_v;
    logic [DATA_W-1:0] r_s1_data;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s2_v;
    norm_result_t      r_s2;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [NREQ-1:0]   w_grant;
    logic [ID_W-1:0]   w_grant_id;
    logic [DATA_W-1:0] w_sel_data;
    logic [LZ_W-1:0]   w_lz;

    assign w_s2_adv = !r_s2_v || out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;

    // Grants are suppressed during reset so nothing is accepted in that cycle.
    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_s1_adv && !rst),
        .i_req   (req_valid),
        .o_grant (w_grant),
        .o_id    (w_grant_id)
    );

    assign req_ready  = w_grant;
    assign w_sel_data = req_data[int'(w_grant_id) * DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_id   <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= (w_grant != '0);
            if (w_grant != '0) begin
                r_s1_data <= w_sel_data;
                r_s1_id   <= w_grant_id;
            end
        end
    end

    lzc32 u_lzc (
        .i_data (r_s1_data),
        .o_lz   (w_lz)
    );

    // A shift by 32 yields zero, which covers the all-zero operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v <= 1'b0;
            r_s2   <= '0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2.id   <= MAX_ID_W'(r_s1_id);
                r_s2.lz   <= w_lz;
                r_s2.mant <= r_s1_data << w_lz;
                r_s2.zero <= (r_s1_data == '0);
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_id    = ID_W'(r_s2.id);
    assign out_lz    = r_s2.lz;
    assign out_mant  = r_s2.mant;
    assign out_zero  = r_s2.zero;
endmodule
